// File: rtl/ccip_avmm_pkg.sv
// Shared constants and types for the CCI-P AVMM host write path.
// Width defaults, the legal burst limit and the arbiter state encoding live here.
package ccip_avmm_pkg;

  localparam int CCIP_AVMM_REQUESTOR_WR_ADDR_WIDTH = 49;
  localparam int CCIP_AVMM_REQUESTOR_BURST_WIDTH   = 3;
  localparam int MAX_BURST                         = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // A first-beat burstcount outside 1..MAX_BURST is illegal.
  function automatic logic burst_is_legal(input logic [31:0] bc);
    return (bc != 32'd0) && (bc <= 32'(MAX_BURST));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester that did not win last time wins.
// With no request it points at requester 0 so the master mux rests on s0.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_o
);

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
    gnt_o = 1'b0;
    if (req_i == 2'b11) gnt_o = ~last_grant_i;
    else if (req_i[1])  gnt_o = 1'b1;
  end

endmodule

// File: rtl/avmm_host_wr_arbiter.sv
// Two-requester AVMM write arbiter toward the host write requestor.
// Grants combinationally from IDLE and locks the grant for the length of a burst.
module avmm_host_wr_arbiter
  import ccip_avmm_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = CCIP_AVMM_REQUESTOR_WR_ADDR_WIDTH,
  parameter int BURST_WIDTH = CCIP_AVMM_REQUESTOR_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic                   s0_write,
  input  logic [ADDR_WIDTH-1:0]  s0_address,
  input  logic [DATA_WIDTH-1:0]  s0_writedata,
  input  logic [BURST_WIDTH-1:0] s0_burstcount,
  output logic                   s0_waitrequest,

  input  logic                   s1_write,
  input  logic [ADDR_WIDTH-1:0]  s1_address,
  input  logic [DATA_WIDTH-1:0]  s1_writedata,
  input  logic [BURST_WIDTH-1:0] s1_burstcount,
  output logic                   s1_waitrequest,

  output logic                   m_write,
  output logic [ADDR_WIDTH-1:0]  m_address,
  output logic [DATA_WIDTH-1:0]  m_writedata,
  output logic [BURST_WIDTH-1:0] m_burstcount,
  input  logic                   m_waitrequest,

  output logic                   grant_id,
  output logic                   burst_err
);

  arb_state_e             state_q;
  logic [BURST_WIDTH-1:0] beats_left_q;
  logic                   last_grant_q;
  logic                   grant_id_q;
  logic                   burst_err_q;

  logic rr_gnt, busy, any_req, sel, active, accept, first_legal;

  rr_arb2 u_rr_arb2 (
    .req_i        ({s1_write, s0_write}),
    .last_grant_i (last_grant_q),
    .gnt_o        (rr_gnt)
  );

  always_comb begin
    busy    = (state_q == ST_BURST);
    any_req = s0_write | s1_write;
    sel     = busy ? grant_id_q : rr_gnt;
    // Reset forces the handshake quiet even though the datapath is combinational.
    active  = reset_n && (busy || any_req);

    m_write      = reset_n && (sel ? s1_write : s0_write);
    m_address    = sel ? s1_address    : s0_address;
    m_writedata  = sel ? s1_writedata  : s0_writedata;
    m_burstcount = sel ? s1_burstcount : s0_burstcount;

    s0_waitrequest = !(active && !sel) || m_waitrequest;
    s1_waitrequest = !(active &&  sel) || m_waitrequest;

    grant_id    = reset_n ? (active ? sel : grant_id_q) : 1'b0;
    accept      = m_write && !m_waitrequest;
    first_legal = burst_is_legal(32'(m_burstcount));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      burst_err_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (any_req) grant_id_q <= sel;
          if (accept) begin
            if (!first_legal) burst_err_q <= 1'b1;
            // Illegal counts collapse to a single beat.
            if (first_legal && (m_burstcount > BURST_WIDTH'(1))) begin
              state_q      <= ST_BURST;
              beats_left_q <= m_burstcount - BURST_WIDTH'(1);
            end else begin
              last_grant_q <= sel;
            end
          end
        end
        ST_BURST: begin
          if (accept) begin
            if (beats_left_q == BURST_WIDTH'(1)) begin
              state_q      <= ST_IDLE;
              beats_left_q <= '0;
              last_grant_q <= grant_id_q;
            end else begin
              beats_left_q <= beats_left_q - BURST_WIDTH'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign burst_err = burst_err_q;

endmodule
